control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the 32-bit bus-based CPU. It steps through fetch (T0–T2) and per-opcode execute states (T3–T7), driving the same datapath control strobes that a bench would otherwise drive by hand. It sits between the IR/CON outputs of the datapath and all register-enable, bus-select and memory strobes. It executes one instruction at a time with no overlap.

## Interface
Parameters:
- ADD_OP, 5'b00011, ALU op forced for address, immediate and branch-target arithmetic

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset_n  in  1  reset, synchronous, active-low
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON  in  1  branch-condition flag from the CON FF
- Stop  in  1  request to halt at the next instruction boundary
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout  out  1 each  bus drivers
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/strobes
- Read, Write, IncPC  out  1 each  memory and PC-increment strobes
- AluOp  out  5  ALU function; only meaningful while Zin=1, 0 otherwise
- Run  out  1  1 while executing, 0 in RST/HALT
- IllegalOp  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: RST, T0–T7, HALT. Outputs are Moore, decoded from the state register and IR. They are valid for the whole cycle of the state.
- Fetch:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Execute by opcode. Each list ends with the last state; the next state is T0 (or HALT).
  - ld 00000:
    - T3 Grb, BAout, Yin.
    - T4 Cout, Zin, AluOp=ADD.
    - T5 ZLOout, MARin.
    - T6 Read, MDRin.
    - T7 MDRout, Gra, Rin.
  - ldi 00001: T3–T4 as ld; T5 ZLOout, Gra, Rin.
  - st 00010:
    - T3–T5 as ld.
    - T6 Gra, Rout, MDRin (Read=0).
    - T7 Write.
  - add 00011, sub 00100, and 00101, or 00110:
    - T3 Grb, Rout, Yin.
    - T4 Grc, Rout, Zin, AluOp=opcode.
    - T5 ZLOout, Gra, Rin.
  - addi 01100: T3 Grb, Rout, Yin; T4 Cout, Zin, AluOp=ADD; T5 ZLOout, Gra, Rin.
  - br 10010:
    - T3 Gra, Rout, CONin.
    - T4 PCout, Yin.
    - T5 Cout, Zin, AluOp=ADD.
    - T6 ZLOout, and PCin only if CON=1.
  - jr 10100: T3 Gra, Rout, PCin.
  - jal 10011: T3 PCout, Grb, Rin (link register in Rb field); T4 Gra, Rout, PCin.
  - in 10110: T3 INPORTout, Gra, Rin.
  - out 10111: T3 Gra, Rout, OUTPORTin.
  - mfhi 11000: T3 HIout, Gra, Rin.
  - mflo 11001: T3 LOout, Gra, Rin.
  - nop 11010: T3 no strobes.
  - halt 11011: T3 no strobes, then HALT.
- Any other opcode: IllegalOp=1 during T3, no other strobes, then T0.
- Instruction boundary:
  - Leaving the last execute state goes to HALT if Stop=1, else to T0.
  - Stop is ignored mid-instruction.
- HALT is sticky: all strobes 0, Run=0. Only Reset_n exits it.

## Timing
- Reset_n=0 at a rising edge forces RST from any state, including mid-instruction.
- In RST all outputs are 0 (Run=0, IllegalOp=0, AluOp=0).
- The first edge with Reset_n=1 moves RST→T0; Run=1 from T0 on.
- One state per clock. The datapath samples enables on the edge that ends the state.
- Cycle count from T0 to the next T0:
  - ld and st: 8.
  - ldi, ALU, addi: 6.
  - br: 7, independent of CON.
  - jal: 5.
  - jr, in, out, mfhi, mflo, nop, illegal: 4.
- CON is sampled combinationally during T6 of br. It was latched by CONin at the end of T3.
- Read and Write are never asserted together. At most one bus driver is high in any state.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (5-bit);
  - state encoding (4-bit, RST=0);
  - ALU op codes, with ADD=5'b00011 shared with the datapath ALU.
- One sub-module, cs_decode: a combinational opcode → instruction-class/last-state decode used by the next-state logic.
- Top module: state register, next-state logic, output decode.

## Test plan
- Reset: Reset_n=0 for 2 cycles during ld T5.
  - Required: all outputs 0, Run=0.
  - After release: one RST cycle, then T0 with PCout=MARin=1.
- brzr R6,25, IR=0x93000019:
  - With CON=1: T6 ZLOout=PCin=1.
  - With CON=0: T6 PCin=0.
  - Both cases: T5 AluOp=00011, and T0 again 7 cycles after the first T0.
- ld, IR opcode 00000:
  - T6 Read=MDRin=1; T7 MDRout=Gra=Rin=1.
  - Next T0 exactly 8 cycles after the first T0; Write never 1.
- add and sub:
  - add: T4 AluOp=00011 with Grc=Rout=Zin=1.
  - sub: T4 AluOp=00100.
  - Both: AluOp=0 in every state where Zin=0.
- Stop asserted during ld T4:
  - ld completes through T7, then HALT with Run=0.
  - Deasserting Stop has no effect until Reset_n.
- Opcode 11111: IllegalOp=1 for exactly the T3 cycle, then T0. Opcode 11011: HALT after T3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control-sequencer states, instruction classes and ALU codes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU function codes are the datapath's; ADD is shared with address arithmetic.
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_LD   = 4'd0,
    CL_LDI  = 4'd1,
    CL_ST   = 4'd2,
    CL_ALU  = 4'd3,
    CL_ADDI = 4'd4,
    CL_BR   = 4'd5,
    CL_JR   = 4'd6,
    CL_JAL  = 4'd7,
    CL_IN   = 4'd8,
    CL_OUT  = 4'd9,
    CL_MFHI = 4'd10,
    CL_MFLO = 4'd11,
    CL_NOP  = 4'd12,
    CL_HALT = 4'd13,
    CL_ILL  = 4'd14
  } iclass_t;

endpackage

// File: rtl/cs_decode.sv
// Opcode decode: instruction class and the final execute state of that class.
module cs_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output state_t     last_state
);

  // Classify the opcode and pick where its execute phase ends
  always_comb begin
    iclass     = CL_ILL;
    last_state = ST_T3;
    case (opcode)
      OP_LD:   begin iclass = CL_LD;   last_state = ST_T7; end
      OP_LDI:  begin iclass = CL_LDI;  last_state = ST_T5; end
      OP_ST:   begin iclass = CL_ST;   last_state = ST_T7; end
      OP_ADD, OP_SUB, OP_AND, OP_OR:
               begin iclass = CL_ALU;  last_state = ST_T5; end
      OP_ADDI: begin iclass = CL_ADDI; last_state = ST_T5; end
      OP_BR:   begin iclass = CL_BR;   last_state = ST_T6; end
      OP_JAL:  begin iclass = CL_JAL;  last_state = ST_T4; end
      OP_JR:   begin iclass = CL_JR;   last_state = ST_T3; end
      OP_IN:   begin iclass = CL_IN;   last_state = ST_T3; end
      OP_OUT:  begin iclass = CL_OUT;  last_state = ST_T3; end
      OP_MFHI: begin iclass = CL_MFHI; last_state = ST_T3; end
      OP_MFLO: begin iclass = CL_MFLO; last_state = ST_T3; end
      OP_NOP:  begin iclass = CL_NOP;  last_state = ST_T3; end
      OP_HALT: begin iclass = CL_HALT; last_state = ST_T3; end
      default: begin iclass = CL_ILL;  last_state = ST_T3; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-class execute T3-T7, sticky HALT.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  output logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, Write, IncPC,
  output logic [4:0]  AluOp,
  output logic        Run,
  output logic        IllegalOp
);

  state_t     state_q, state_d;
  iclass_t    iclass;
  state_t     last_state;
  logic [4:0] opcode;
  logic       ir_unused;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  cs_decode u_decode (
    .opcode     (opcode),
    .iclass     (iclass),
    .last_state (last_state)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset_n) state_q <= ST_RST;
    else          state_q <= state_d;
  end

  // Next state: Stop only matters when leaving the final execute state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (state_q == last_state) begin
          if (iclass == CL_HALT || Stop) state_d = ST_HALT;
          else                           state_d = ST_T0;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // Moore output decode from state and instruction class
  always_comb begin
    {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = 10'd0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout}     = 8'd0;
    {Gra, Grb, Grc, Rin, Rout, BAout}                                  = 6'd0;
    {Read, Write, IncPC}                                               = 3'd0;
    AluOp     = 5'd0;
    IllegalOp = 1'b0;
    if (state_q == ST_RST || state_q == ST_HALT) Run = 1'b0;
    else                                         Run = 1'b1;
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; end
      ST_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (iclass)
          CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_ALU, CL_ADDI:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CL_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          CL_IN:   begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          CL_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ILL:  IllegalOp = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (iclass)
          CL_LD, CL_LDI, CL_ST, CL_ADDI: begin Cout = 1'b1; Zin = 1'b1; AluOp = ADD_OP; end
          CL_ALU:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; AluOp = opcode; end
          CL_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          CL_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (iclass)
          CL_LD, CL_ST:             begin ZLOout = 1'b1; MARin = 1'b1; end
          CL_LDI, CL_ALU, CL_ADDI:  begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_BR:   begin Cout = 1'b1; Zin = 1'b1; AluOp = ADD_OP; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (iclass)
          CL_LD:   begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_BR: begin
            ZLOout = 1'b1;
            if (CON) PCin = 1'b1;
            else     PCin = 1'b0;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (iclass)
          CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
